// File: rtl/neuron_cfg_arbiter.sv
// Round-robin owner of the neuron's byte-serial config port: parses opcode length, holds grant per packet, paces strobes.
// Optional feature: define NEURO_ARB_TIMEOUT_EN to pad a stalled packet with 8'h00 bytes after TIMEOUT cycles.
module neuron_cfg_arbiter #(
    parameter int         NUM_REQ        = 2,
    parameter int         GAP_CYCLES     = 2,
    parameter logic [7:0] OP_CTRL        = 8'h01,
    parameter logic [7:0] OP_WEIGHT      = 8'h02,
    parameter logic [7:0] OP_ADDR_WEIGHT = 8'h03,
    parameter logic [7:0] OP_END         = 8'hFF
`ifdef NEURO_ARB_TIMEOUT_EN
   ,parameter int         TIMEOUT        = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 load_data,
    output logic [7:0]           data,
    output logic                 pkt_done,
    output logic                 err
);

    // state   | meaning
    // IDLE    | no owner, searching from rr pointer
    // FETCH   | waiting for the owner's next byte
    // PULSE   | load_data high for one cycle
    // GAP     | load_data low for GAP_CYCLES cycles
    // RELEASE | drop grant, pulse pkt_done/err, advance rr pointer
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PULSE, S_GAP, S_RELEASE
    } state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   g_idx_q, g_idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               load_data_q, load_data_d;
    logic [7:0]         data_q, data_d;
    logic               pkt_done_q, pkt_done_d;
    logic               err_q, err_d;
    logic               err_pend_q, err_pend_d;
    logic [3:0]         rem_q, rem_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [7:0]         byte_in;
    logic               src_vld;
    logic               op_known;
    logic [3:0]         op_rem;
    logic               flushing;

`ifdef NEURO_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    logic             flush_q, flush_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign flushing = flush_q;
`else
    assign flushing = 1'b0;
`endif

    assign byte_in   = req_data[{g_idx_q, 3'b000} +: 8];
    assign src_vld   = req_valid[g_idx_q];
    assign req_ready = (state_q == S_FETCH && !flushing) ? (grant_q & req_valid) : '0;

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign load_data = load_data_q;
    assign data      = data_q;
    assign pkt_done  = pkt_done_q;
    assign err       = err_q;

    // First valid requester at or after the rr pointer, wrapping mod NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Bytes still to follow the opcode.
    always_comb begin
        op_known = 1'b1;
        op_rem   = 4'd0;
        if (byte_in == OP_CTRL)             op_rem = 4'd2;
        else if (byte_in == OP_WEIGHT)      op_rem = 4'd6;
        else if (byte_in == OP_ADDR_WEIGHT) op_rem = 4'd8;
        else if (byte_in == OP_END)         op_rem = 4'd0;
        else                                op_known = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        g_idx_d     = g_idx_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        data_d      = data_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        err_pend_d  = err_pend_q;
        load_data_d = 1'b0;
        pkt_done_d  = 1'b0;
        err_d       = 1'b0;
`ifdef NEURO_ARB_TIMEOUT_EN
        flush_d     = flush_q;
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    g_idx_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    rem_d             = 4'd0;
                    err_pend_d        = 1'b0;
`ifdef NEURO_ARB_TIMEOUT_EN
                    flush_d           = 1'b0;
                    tmo_d             = TMO_W'(TIMEOUT - 1);
`endif
                    state_d           = S_FETCH;
                end
            end
            S_FETCH: begin
                if (flushing) begin
                    data_d      = 8'h00;
                    rem_d       = rem_q - 4'd1;
                    load_data_d = 1'b1;
                    state_d     = S_PULSE;
                end else if (src_vld) begin
                    if (rem_q == 4'd0 && !op_known) begin
                        err_pend_d = 1'b1;
                        state_d    = S_RELEASE;
                    end else begin
                        data_d      = byte_in;
                        rem_d       = (rem_q == 4'd0) ? op_rem : rem_q - 4'd1;
                        load_data_d = 1'b1;
                        state_d     = S_PULSE;
                    end
                end
`ifdef NEURO_ARB_TIMEOUT_EN
                // Source stalled mid-packet: pad the rest with zeros so downstream finishes its packet.
                else if (rem_q != 4'd0) begin
                    if (tmo_q == '0) begin
                        flush_d     = 1'b1;
                        err_pend_d  = 1'b1;
                        data_d      = 8'h00;
                        rem_d       = rem_q - 4'd1;
                        load_data_d = 1'b1;
                        state_d     = S_PULSE;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
`endif
            end
            S_PULSE: begin
                gap_d   = GAP_W'(GAP_CYCLES - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (rem_q != 4'd0) begin
                        state_d = S_FETCH;
`ifdef NEURO_ARB_TIMEOUT_EN
                        tmo_d   = TMO_W'(TIMEOUT - 1);
`endif
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_RELEASE: begin
                grant_d    = '0;
                busy_d     = 1'b0;
                pkt_done_d = !err_pend_q;
                err_d      = err_pend_q;
                rr_d       = (g_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx_q + IDX_W'(1);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            g_idx_q     <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            load_data_q <= 1'b0;
            data_q      <= 8'h00;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            rem_q       <= 4'd0;
            gap_q       <= '0;
`ifdef NEURO_ARB_TIMEOUT_EN
            flush_q     <= 1'b0;
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            g_idx_q     <= g_idx_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            load_data_q <= load_data_d;
            data_q      <= data_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
`ifdef NEURO_ARB_TIMEOUT_EN
            flush_q     <= flush_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_cfg_arbiter.sv
// Bench for neuron_cfg_arbiter: vector table of single packets plus hand sequences for ties, errors and reset.
// Expected strobes are queued when packets are handed to the requester models and popped on each strobe.
module tb_neuron_cfg_arbiter;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            busy, load_data, pkt_done, err;
    logic [7:0]      data;

    neuron_cfg_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .busy(busy), .load_data(load_data),
        .data(data), .pkt_done(pkt_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int src; logic [7:0] byte_v; } exp_t;
    typedef struct {
        int              src;
        int              len;
        logic [0:8][7:0] b;
        logic            exp_err;
        int              exp_cyc;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [NR-1:0] hs;
    vec_t       vecs[6];

    int checks = 0, errors = 0;
    int strobe_cnt = 0, err_cnt = 0, done_cnt = 0;
    int pkt_strobes = 0, last_strobe = 0;
    logic ld_prev = 1'b0;
    bit chk_spacing = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Requester models: present queued bytes, pop after the handshake edge.
    initial begin
        req_valid = '0;
        req_data  = '0;
        hs        = '0;
        forever begin
            @(negedge clk);
            if (hs[0] && q0.size() > 0) q0.delete(0);
            if (hs[1] && q1.size() > 0) q1.delete(1 - 1);
            req_valid[0]     = (q0.size() > 0);
            req_data[7:0]    = (q0.size() > 0) ? q0[0] : 8'h00;
            req_valid[1]     = (q1.size() > 0);
            req_data[15:8]   = (q1.size() > 0) ? q1[0] : 8'h00;
            #1;
            hs = req_ready;
        end
    end

    // Strobe monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (pkt_done) done_cnt++;
        if (!busy) pkt_strobes = 0;
        if ((req_valid & ~grant) != '0)
            check("ready_nongranted", 32'(req_ready & ~grant), 32'd0);
        if (load_data) begin
            check("strobe_width", {31'd0, ld_prev}, 32'd0);
            if (!ld_prev) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: data %0h with nothing expected", data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_data", 32'(data), 32'(mon_e.byte_v));
                    check("strobe_owner", 32'(grant), 32'd1 << mon_e.src);
                end
                if (chk_spacing && pkt_strobes > 0)
                    check("strobe_spacing", cyc - last_strobe, 32'd4);
                pkt_strobes++;
                last_strobe = cyc;
            end
        end
        ld_prev = load_data;
    end

    task automatic send(input int src, input logic [0:8][7:0] b, input int len, input bit fwd);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            if (src == 0) q0.push_back(b[i]);
            else          q1.push_back(b[i]);
            if (fwd) begin
                e.src    = src;
                e.byte_v = b[i];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int guard;
        guard = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || busy) && guard < maxc) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check({name, "_sb_empty"}, exp_q.size(), 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int c0, guard;
        @(posedge clk); #2;
        send(v.src, v.b, v.len, !v.exp_err);
        guard = 0;
        while (grant == '0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        c0 = cyc;
        check($sformatf("vec%0d_grant", idx), 32'(grant), 32'd1 << v.src);
        check($sformatf("vec%0d_busy_on", idx), {31'd0, busy}, 32'd1);
        guard = 0;
        while (!(pkt_done || err) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("vec%0d_latency", idx), cyc - c0, v.exp_cyc);
        check($sformatf("vec%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("vec%0d_done", idx), {31'd0, pkt_done}, {31'd0, !v.exp_err});
        check($sformatf("vec%0d_released", idx), {30'd0, grant}, 32'd0);
        wait_idle($sformatf("vec%0d", idx), 50);
    endtask

    logic [0:8][7:0] pk_ff, pk_bad, pk_w, pk_aw0, pk_aw1;
    int s0, d0, e0, guard;

    initial begin
        vecs[0] = '{src: 0, len: 3, b: {8'h01, 8'h2A, 8'h01, 48'h0}, exp_err: 1'b0, exp_cyc: 13};
        vecs[1] = '{src: 0, len: 1, b: {8'hFF, 64'h0}, exp_err: 1'b0, exp_cyc: 5};
        vecs[2] = '{src: 1, len: 1, b: {8'h07, 64'h0}, exp_err: 1'b1, exp_cyc: 2};
        vecs[3] = '{src: 1, len: 7, b: {56'h02_11_22_33_44_55_66, 16'h0}, exp_err: 1'b0, exp_cyc: 29};
        vecs[4] = '{src: 0, len: 9, b: 72'h03_C1_C2_A1_A2_10_20_30_40, exp_err: 1'b0, exp_cyc: 37};
        vecs[5] = '{src: 1, len: 3, b: {24'h01_AA_55, 48'h0}, exp_err: 1'b0, exp_cyc: 13};
        pk_ff  = {8'hFF, 64'h0};
        pk_bad = {8'h07, 64'h0};
        pk_w   = {56'h02_11_22_33_44_55_66, 16'h0};
        pk_aw0 = 72'h03_01_02_03_04_05_06_07_08;
        pk_aw1 = 72'h03_F1_F2_F3_F4_F5_F6_F7_F8;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_load_data", {31'd0, load_data}, 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Tie between two 9-byte packets, then a second tie that must go back to req0.
        @(posedge clk); #2;
        send(0, pk_aw0, 9, 1'b1);
        send(1, pk_aw1, 9, 1'b1);
        wait_idle("tie_addr_weight", 300);
        @(posedge clk); #2;
        send(0, pk_ff, 1, 1'b1);
        send(1, pk_ff, 1, 1'b1);
        wait_idle("tie_end", 100);

        // Unknown opcode from req1 must still advance the rr pointer to 0.
        @(posedge clk); #2;
        send(0, pk_ff, 1, 1'b1);
        wait_idle("rr_to_1", 50);
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk); #2;
        send(1, pk_bad, 1, 1'b0);
        wait_idle("bad_opcode", 50);
        check("bad_opcode_err_pulses", err_cnt - e0, 32'd1);
        check("bad_opcode_no_done", done_cnt - d0, 32'd0);
        @(posedge clk); #2;
        send(0, pk_ff, 1, 1'b1);
        send(1, pk_ff, 1, 1'b1);
        wait_idle("tie_after_err", 100);

        // Reset in the middle of a weight packet while rr pointer sits at 1.
        @(posedge clk); #2;
        send(0, pk_ff, 1, 1'b1);
        wait_idle("rr_to_1_again", 50);
        @(posedge clk); #2;
        s0 = strobe_cnt;
        send(0, pk_w, 7, 1'b1);
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
            if (strobe_cnt >= s0 + 4) break;
        end
        check("midpkt_strobe_count", strobe_cnt - s0, 32'd4);
        check("midpkt_load_data_high", {31'd0, load_data}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_load_data", {31'd0, load_data}, 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        hs = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        send(0, pk_ff, 1, 1'b1);
        send(1, pk_ff, 1, 1'b1);
        wait_idle("tie_after_reset", 100);

`ifdef NEURO_ARB_TIMEOUT_EN
        chk_spacing = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk); #2;
        send(0, pk_w, 2, 1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back('{src: 0, byte_v: 8'h00});
        guard = 0;
        while (err_cnt == e0 && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("tmo_err_pulses", err_cnt - e0, 32'd1);
        check("tmo_no_done", done_cnt - d0, 32'd0);
        wait_idle("tmo", 50);
        chk_spacing = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
